// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

  // Slot tags are stored at a fixed width so the record type can live here;
  // the controller zero-extends its RW-bit tags, so NREG may be up to 256.
  localparam int TAG_W_MAX = 8;

  // EX operand source select
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EXM = 2'b01;
  localparam logic [1:0] FWD_MWB = 2'b10;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] rd;
    logic                 we;
    logic                 load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A source depends on a slot only if it is actually read and the slot
  // really writes a non-zero register with the same tag.
  function automatic logic slot_match(input logic                 src_used,
                                      input logic [TAG_W_MAX-1:0] src_tag,
                                      input slot_t                s);
    return src_used && s.valid && s.we && (s.rd != '0) && (s.rd == src_tag);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up on inc, sticking at all-ones instead of wrapping
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB destinations, decides
// front-end stalls, bubbles and flushes, and registers operand forwarding.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int NREG   = 32,
  parameter  int FWD_EN = 1,
  parameter  int REG_WT = 1,
  parameter  int CNT_W  = 16,
  localparam int RW     = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_we,
  input  logic             id_load,
  input  logic             ex_busy,
  input  logic             ex_redirect,
  output logic             stall_fe,
  output logic             bubble_ex,
  output logic             flush_fd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             proto_err
);

  logic [TAG_W_MAX-1:0] rs1_x;
  logic [TAG_W_MAX-1:0] rs2_x;
  slot_t                id_slot;
  slot_t                slot_ex;
  slot_t                slot_mem;
  slot_t                slot_wb;

  logic m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
  logic m_ex, m_mem, m_wb;
  logic raw_hazard;
  logic hazard;
  logic redirect_acc;
  logic issue;
  logic [1:0] sel_a;
  logic [1:0] sel_b;

  assign rs1_x = TAG_W_MAX'(id_rs1);
  assign rs2_x = TAG_W_MAX'(id_rs2);

  // Record the ID instruction as it would look once it enters EX
  always_comb begin
    id_slot       = SLOT_EMPTY;
    id_slot.valid = 1'b1;
    id_slot.rd    = TAG_W_MAX'(id_rd);
    id_slot.we    = id_we;
    id_slot.load  = id_load;
  end

  // Per-source dependency checks against every in-flight slot
  always_comb begin
    m_ex1  = slot_match(id_use1, rs1_x, slot_ex);
    m_ex2  = slot_match(id_use2, rs2_x, slot_ex);
    m_mem1 = slot_match(id_use1, rs1_x, slot_mem);
    m_mem2 = slot_match(id_use2, rs2_x, slot_mem);
    m_wb1  = slot_match(id_use1, rs1_x, slot_wb);
    m_wb2  = slot_match(id_use2, rs2_x, slot_wb);
    m_ex   = m_ex1  | m_ex2;
    m_mem  = m_mem1 | m_mem2;
    m_wb   = m_wb1  | m_wb2;
  end

  // Decide whether the ID instruction must wait. With forwarding only a
  // load still in EX is too late; without it any EX/MEM producer is.
  // A WB producer is only a problem when the register file cannot
  // bypass its own write into a same-cycle read.
  always_comb begin
    raw_hazard = 1'b0;
    if (FWD_EN != 0) begin
      raw_hazard = (m_ex & slot_ex.load) | ((REG_WT == 0) & m_wb);
    end else begin
      raw_hazard = m_ex | m_mem | ((REG_WT == 0) & m_wb);
    end
    hazard = id_valid & raw_hazard;
  end

  // Pipeline control, priority busy > redirect > hazard; all quiet in reset
  always_comb begin
    stall_fe  = 1'b0;
    bubble_ex = 1'b0;
    flush_fd  = 1'b0;
    if (reset) begin
      if (ex_busy) begin
        stall_fe = 1'b1;
      end else if (ex_redirect) begin
        flush_fd  = 1'b1;
        bubble_ex = 1'b1;
      end else if (hazard) begin
        stall_fe  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

  assign redirect_acc = reset & ex_redirect & ~ex_busy;
  assign issue        = id_valid & ~stall_fe & ~redirect_acc;

  // Youngest producer wins: EX/MEM result beats MEM/WB result
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (FWD_EN != 0) begin
      if (m_ex1)       sel_a = FWD_EXM;
      else if (m_mem1) sel_a = FWD_MWB;
      if (m_ex2)       sel_b = FWD_EXM;
      else if (m_mem2) sel_b = FWD_MWB;
    end
  end

  // Slot shift register; a busy EX keeps its instruction and emits holes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_ex  <= SLOT_EMPTY;
      slot_mem <= SLOT_EMPTY;
      slot_wb  <= SLOT_EMPTY;
    end else if (ex_busy) begin
      slot_mem <= SLOT_EMPTY;
      slot_wb  <= slot_mem;
    end else begin
      slot_ex  <= issue ? id_slot : SLOT_EMPTY;
      slot_mem <= slot_ex;
      slot_wb  <= slot_mem;
    end
  end

  // Forwarding selects follow the instruction entering EX; bubbles read RF
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else if (!ex_busy) begin
      if (issue) begin
        fwd_a <= sel_a;
        fwd_b <= sel_b;
      end else begin
        fwd_a <= FWD_RF;
        fwd_b <= FWD_RF;
      end
    end
  end

  // A redirect while EX is busy cannot be honoured; remember it until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err <= 1'b0;
    end else if (ex_redirect && ex_busy) begin
      proto_err <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (stall_fe),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (redirect_acc),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a forwarding instance (default params)
// and a stall-only instance with a narrow counter share the same stimulus.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use1, id_use2, id_we, id_load;
  logic       ex_busy, ex_redirect;

  logic        stall_fe0, bubble_ex0, flush_fd0, proto_err0;
  logic [1:0]  fwd_a0, fwd_b0;
  logic [15:0] stall_cnt0, flush_cnt0;

  logic        stall_fe1, bubble_ex1, flush_fd1, proto_err1;
  logic [1:0]  fwd_a1, fwd_b1;
  logic [2:0]  stall_cnt1, flush_cnt1;

  int n_cmp;
  int n_err;

  hazard_ctrl dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .stall_fe(stall_fe0), .bubble_ex(bubble_ex0), .flush_fd(flush_fd0),
    .fwd_a(fwd_a0), .fwd_b(fwd_b0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0), .proto_err(proto_err0)
  );

  hazard_ctrl #(.FWD_EN(0), .REG_WT(1), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_rd(id_rd), .id_we(id_we), .id_load(id_load),
    .ex_busy(ex_busy), .ex_redirect(ex_redirect),
    .stall_fe(stall_fe1), .bubble_ex(bubble_ex1), .flush_fd(flush_fd1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1), .proto_err(proto_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of ID/EX inputs at the falling edge, settle, return
  task automatic step(input int v, input int r1, input int u1, input int r2, input int u2,
                      input int rd, input int we, input int ld, input int busy, input int redir);
    @(negedge clk);
    id_valid    = 1'(v);
    id_rs1      = 5'(r1);
    id_use1     = 1'(u1);
    id_rs2      = 5'(r2);
    id_use2     = 1'(u2);
    id_rd       = 5'(rd);
    id_we       = 1'(we);
    id_load     = 1'(ld);
    ex_busy     = 1'(busy);
    ex_redirect = 1'(redir);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    // reset with busy+redirect driven: outputs must stay quiet
    reset = 1'b0;
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    id_rd = 5'd0; id_we = 1'b0; id_load = 1'b0; ex_busy = 1'b1; ex_redirect = 1'b1;
    #3;
    check_val("rst_stall",  32'(stall_fe0),  0);
    check_val("rst_bubble", 32'(bubble_ex0), 0);
    check_val("rst_flush",  32'(flush_fd0),  0);
    check_val("rst_fwd",    32'({fwd_a0, fwd_b0}), 0);
    check_val("rst_cnt",    32'({stall_cnt0, flush_cnt0}), 0);
    check_val("rst_perr",   32'(proto_err0), 0);
    @(negedge clk);
    reset = 1'b1; ex_busy = 1'b0; ex_redirect = 1'b0; id_valid = 1'b0;

    // ALU writer x5 followed by reader of x5: forward from EX/MEM
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    check_val("alu_nostall", 32'(stall_fe0),  0);
    check_val("alu_nobub",   32'(bubble_ex0), 0);
    idle(1);
    check_val("alu_fwd_a", 32'(fwd_a0), 1);
    check_val("alu_fwd_b", 32'(fwd_b0), 0);

    // load x7 then reader of rs2=x7: one stall, then MEM/WB forward
    idle(3);
    step(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
    step(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
    check_val("lu_stall",  32'(stall_fe0),  1);
    check_val("lu_bubble", 32'(bubble_ex0), 1);
    check_val("lu_noflsh", 32'(flush_fd0),  0);
    step(1, 0, 0, 7, 1, 8, 1, 0, 0, 0);
    check_val("lu_stall_end", 32'(stall_fe0), 0);
    check_val("lu_bub_fwd",   32'(fwd_b0),    0);
    idle(1);
    check_val("lu_fwd_b",  32'(fwd_b0),     2);
    check_val("lu_fwd_a",  32'(fwd_a0),     0);
    check_val("lu_scnt",   32'(stall_cnt0), 1);

    // load to x0 then reader of x0: never a dependency
    idle(3);
    step(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 0, 1, 11, 1, 0, 0, 0);
    check_val("x0_nostall", 32'(stall_fe0), 0);
    idle(1);
    check_val("x0_fwd", 32'({fwd_a0, fwd_b0}), 0);

    // redirect during a pending load-use overrides the stall
    idle(3);
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    step(1, 3, 1, 0, 0, 12, 1, 0, 0, 1);
    check_val("rd_flush",  32'(flush_fd0),  1);
    check_val("rd_bubble", 32'(bubble_ex0), 1);
    check_val("rd_stall",  32'(stall_fe0),  0);
    idle(1);
    check_val("rd_fcnt",  32'(flush_cnt0), 1);
    check_val("rd_scnt",  32'(stall_cnt0), 1);
    check_val("rd_fwd_a", 32'(fwd_a0),     0);

    // busy 3 cycles then busy+redirect, with a load held in EX
    idle(3);
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 9, 1, 0, 0, 13, 1, 0, 1, 0);
      check_val("busy_stall", 32'(stall_fe0),  1);
      check_val("busy_nobub", 32'(bubble_ex0), 0);
    end
    step(1, 9, 1, 0, 0, 13, 1, 0, 1, 1);
    check_val("bz_rd_stall", 32'(stall_fe0),  1);
    check_val("bz_rd_noflh", 32'(flush_fd0),  0);
    check_val("bz_rd_nobub", 32'(bubble_ex0), 0);
    step(1, 9, 1, 0, 0, 13, 1, 0, 0, 0);
    check_val("bz_perr",     32'(proto_err0), 1);
    check_val("bz_held_lu",  32'(stall_fe0),  1);
    check_val("bz_held_bub", 32'(bubble_ex0), 1);
    step(1, 9, 1, 0, 0, 13, 1, 0, 0, 0);
    check_val("bz_release", 32'(stall_fe0), 0);
    idle(1);
    check_val("bz_fwd_a", 32'(fwd_a0),     2);
    check_val("bz_scnt",  32'(stall_cnt0), 6);
    check_val("bz_fcnt",  32'(flush_cnt0), 1);
    check_val("bz_perr2", 32'(proto_err0), 1);

    // invalid ID never stalls; then asynchronous reset mid-stall
    idle(3);
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(0, 9, 1, 0, 0, 14, 1, 0, 0, 0);
    check_val("inv_nostall", 32'(stall_fe0), 0);
    step(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);
    step(1, 9, 1, 0, 0, 14, 1, 0, 0, 0);
    check_val("pre_rst_stall", 32'(stall_fe0), 1);
    #2 reset = 1'b0;
    #1;
    check_val("arst_stall", 32'(stall_fe0),  0);
    check_val("arst_bub",   32'(bubble_ex0), 0);
    check_val("arst_perr",  32'(proto_err0), 0);
    check_val("arst_cnt",   32'({stall_cnt0, flush_cnt0}), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("arst_slots", 32'(stall_fe0), 0);

    // stall-only instance: back-to-back RAW stalls exactly twice
    idle(3);
    step(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    step(1, 4, 1, 0, 0, 10, 1, 0, 0, 0);
    check_val("so_stall1", 32'(stall_fe1), 1);
    check_val("so_fwd1",   32'(fwd_a1),    0);
    check_val("fw_nostall", 32'(stall_fe0), 0);
    step(1, 4, 1, 0, 0, 10, 1, 0, 0, 0);
    check_val("so_stall2", 32'(stall_fe1), 1);
    check_val("so_fwd2",   32'(fwd_a1),    0);
    check_val("fw_fwd_a",  32'(fwd_a0),    1);
    step(1, 4, 1, 0, 0, 10, 1, 0, 0, 0);
    check_val("so_stall3", 32'(stall_fe1), 0);
    idle(1);
    check_val("so_fwd_end", 32'({fwd_a1, fwd_b1}), 0);
    check_val("so_scnt",    32'(stall_cnt1), 2);

    // 3-bit counter reaches all-ones and stays there
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check_val("sat_reach", 32'(stall_cnt1), 7);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    check_val("sat_hold", 32'(stall_cnt1), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
